// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command codes {CS#,RAS#,CAS#,WE#}, arbiter state
// encoding and default bus widths.
package sdram_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int BA_W_DEF   = 2;
  localparam int DATA_W_DEF = 16;

  localparam logic [3:0] CMD_NOP        = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
  localparam logic [3:0] CMD_AT_REF     = 4'b0001;
  localparam logic [3:0] CMD_MREG_SET   = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [3:0] CMD_WRITE      = 4'b0100;
  localparam logic [3:0] CMD_READ       = 4'b0101;
  localparam logic [3:0] CMD_BURST_STOP = 4'b0110;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sdram_cmd_mux.sv
// Selects the command, bank and address driven onto the SDRAM pins from the
// requester that currently owns the bus.
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BA_W   = BA_W_DEF
) (
  input  arb_state_e        state_i,
  input  logic [3:0]        init_cmd_i,
  input  logic [BA_W-1:0]   init_ba_i,
  input  logic [ADDR_W-1:0] init_addr_i,
  input  logic [3:0]        aref_cmd_i,
  input  logic [BA_W-1:0]   aref_ba_i,
  input  logic [ADDR_W-1:0] aref_addr_i,
  input  logic [3:0]        wr_cmd_i,
  input  logic [BA_W-1:0]   wr_ba_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [3:0]        rd_cmd_i,
  input  logic [BA_W-1:0]   rd_ba_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [3:0]        cmd_o,
  output logic [BA_W-1:0]   ba_o,
  output logic [ADDR_W-1:0] addr_o
);

  always_comb begin
    cmd_o  = CMD_NOP;
    ba_o   = '1;
    addr_o = '1;
    case (state_i)
      ST_INIT: begin
        cmd_o  = init_cmd_i;
        ba_o   = init_ba_i;
        addr_o = init_addr_i;
      end
      ST_AREF: begin
        cmd_o  = aref_cmd_i;
        ba_o   = aref_ba_i;
        addr_o = aref_addr_i;
      end
      ST_WRITE: begin
        cmd_o  = wr_cmd_i;
        ba_o   = wr_ba_i;
        addr_o = wr_addr_i;
      end
      ST_READ: begin
        cmd_o  = rd_cmd_i;
        ba_o   = rd_ba_i;
        addr_o = rd_addr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sdram_arbit.sv
// Fixed-priority (refresh > write > read) owner of the SDRAM command bus,
// held by the init sequencer until init_end.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BA_W   = BA_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              arb_clk,
  input  logic              arb_rst_n,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              aref_end,
  output logic              aref_en,
  input  logic              wr_req,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_end,
  output logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_sdram_en,
  input  logic              rd_req,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_end,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  arb_state_e state_q, state_d;
  logic       aref_en_q, wr_en_q, rd_en_q;
  logic [3:0] cmd;

  // Grants are registered copies of the next state, so each enable rises with
  // entry into its state and falls on the edge that samples *_end.
  always_ff @(posedge arb_clk) begin
    if (!arb_rst_n) begin
      state_q   <= ST_INIT;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      aref_en_q <= (state_d == ST_AREF);
      wr_en_q   <= (state_d == ST_WRITE);
      rd_en_q   <= (state_d == ST_READ);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (init_end) state_d = ST_ARBIT;
      ST_ARBIT: begin
        if (aref_req)      state_d = ST_AREF;
        else if (wr_req)   state_d = ST_WRITE;
        else if (rd_req)   state_d = ST_READ;
      end
      ST_AREF:  if (aref_end) state_d = ST_ARBIT;
      ST_WRITE: if (wr_end)   state_d = ST_ARBIT;
      ST_READ:  if (rd_end)   state_d = ST_ARBIT;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    sdram_dq_oe  = (state_q == ST_WRITE) && wr_sdram_en;
    sdram_dq_out = sdram_dq_oe ? wr_data : '0;
  end

  sdram_cmd_mux #(
    .ADDR_W (ADDR_W),
    .BA_W   (BA_W)
  ) u_cmd_mux (
    .state_i     (state_q),
    .init_cmd_i  (init_cmd),
    .init_ba_i   (init_ba),
    .init_addr_i (init_addr),
    .aref_cmd_i  (aref_cmd),
    .aref_ba_i   (aref_ba),
    .aref_addr_i (aref_addr),
    .wr_cmd_i    (wr_cmd),
    .wr_ba_i     (wr_ba),
    .wr_addr_i   (wr_addr),
    .rd_cmd_i    (rd_cmd),
    .rd_ba_i     (rd_ba),
    .rd_addr_i   (rd_addr),
    .cmd_o       (cmd),
    .ba_o        (sdram_ba),
    .addr_o      (sdram_addr)
  );

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke = 1'b1;
  assign aref_en   = aref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Arbiter and command multiplexer sitting between the SDRAM initialisation, auto-refresh, write and read command generators and the SDRAM pins. It holds the bus for the initialisation sequencer until `init_end`, then grants the single command/address/data bus to one requester at a time with fixed priority (refresh > write > read). It drives CKE, the command pins, the bank and address pins, and the write-data output enable.

## Interface
Parameters:
- `ADDR_W`, 13, SDRAM address width
- `BA_W`, 2, bank address width
- `DATA_W`, 16, DQ width

Ports:
- `arb_clk` in 1: system clock, 100 MHz
- `arb_rst_n` in 1: reset, synchronous, active-low
- `init_cmd`/`init_ba`/`init_addr` in 4/BA_W/ADDR_W: init command {CS#,RAS#,CAS#,WE#}, bank and address
- `init_end` in 1: init complete, held high
- `aref_req` in 1: refresh request, held high until granted
- `aref_cmd`/`aref_ba`/`aref_addr` in 4/BA_W/ADDR_W: refresh command, bank and address
- `aref_end` in 1: 1-cycle pulse, refresh done
- `aref_en` out 1: refresh grant
- `wr_req`, `wr_cmd`, `wr_ba`, `wr_addr`, `wr_end`, `wr_en`: same roles for write
- `wr_data` in DATA_W: write data
- `wr_sdram_en` in 1: write module is driving data this cycle
- `rd_req`, `rd_cmd`, `rd_ba`, `rd_addr`, `rd_end`, `rd_en`: same roles for read
- `sdram_cke` out 1: clock enable
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n` out 1 each: command pins
- `sdram_ba` out BA_W: bank pins
- `sdram_addr` out ADDR_W: address pins
- `sdram_dq_out` out DATA_W: write data to the pad
- `sdram_dq_oe` out 1: pad output enable

## Operation
The arbiter is a state machine with five states: INIT, ARBIT, AREF, WRITE, READ.

- **INIT**
  - Pins carry `init_*`.
  - Go to ARBIT when `init_end` is 1.
- **ARBIT**
  - Pins carry NOP (0111), ba all-ones, addr all-ones.
  - Pick the next state by priority: `aref_req` goes to AREF, else `wr_req` goes to WRITE, else `rd_req` goes to READ, else stay in ARBIT.
- **AREF / WRITE / READ**
  - Pins carry the granted module's cmd, ba and addr.
  - Return to ARBIT on that module's `*_end`.
- **Requests outside ARBIT** are ignored. They are not latched; requesters keep `*_req` high until they see their `*_en`.
- **Enables.** `*_en` are registered.
  - Each sets on the ARBIT→X transition, so it is high in the first cycle of state X.
  - It clears on the edge where `*_end` is sampled.
  - At most one `*_en` is high at any time.
- **Data pins.**
  - `sdram_dq_oe` = (state==WRITE) & `wr_sdram_en`.
  - `sdram_dq_out` = `wr_data` when oe is 1, else 0.
- **CKE.** `sdram_cke` is a constant 1.
- **Pin muxing** is combinational from the registered state. The source modules register their own outputs.
- **Illegal state encoding** recovers to INIT.

## Timing
- **Reset values.**
  - State: INIT.
  - `aref_en`, `wr_en`, `rd_en`: 0.
  - `sdram_cke`: 1.
  - `sdram_dq_oe`: 0. `sdram_dq_out`: 0.
  - Command, ba and addr pins follow `init_*`; these read NOP/11/1FFF while the init module is in reset.
- **Reset mid-operation.** Taken on the next edge: state goes to INIT and all `*_en` clear.
- **Grant latency.**
  - A request sampled in ARBIT at edge N gives state=X and `*_en`=1 after edge N.
  - The module's command reaches the pins in that same cycle.
- **Release.**
  - `*_end` sampled at edge M gives state=ARBIT and `*_en`=0 after edge M.
  - At least one ARBIT cycle (NOP on the pins) separates consecutive grants.
- **Simultaneous events.**
  - Several requests in the same ARBIT cycle: the highest-priority one wins.
  - `*_end` together with a new request: the end is honoured first; the request is evaluated in the following ARBIT cycle.
- **`init_end` dropping after INIT** is ignored; only reset returns the arbiter to INIT.

## Structure
- Shared package `sdram_pkg` holds:
  - command codes NOP, PRECHARGE, AT_REF, MREG_SET, ACTIVE, WRITE, READ, BURST_STOP
  - the arbiter state encoding
  - default widths
- One natural sub-module, `sdram_cmd_mux`: combinational selection of cmd/ba/addr by state.

## Test plan
- **Init hand-off.** `init_cmd`=0010 with `init_end`=0 → pins show 0010. Raise `init_end` → next cycle state ARBIT and pins NOP/11/1FFF.
- **Priority.** `aref_req`, `wr_req` and `rd_req` all 1 in ARBIT → `aref_en`=1 next cycle.
  - After `aref_end`, one NOP cycle, then `wr_en`=1.
  - After `wr_end`, one NOP cycle, then `rd_en`=1.
- **Write data.**
  - In WRITE with `wr_sdram_en`=1 and `wr_data`=16'hA5A5 → `sdram_dq_oe`=1 and `sdram_dq_out`=A5A5.
  - With `wr_sdram_en`=0 → oe=0.
- **Request during busy.** `aref_req` rises while in READ → ignored until `rd_end`; then ARBIT for one cycle, then `aref_en`=1.
- **Reset mid-write.** `arb_rst_n`=0 while `wr_en`=1 → after the next edge `wr_en`=0, state INIT, oe=0, cke=1.
- **Idle.** No requests after init → pins stay NOP/11/1FFF and all `*_en` stay 0 for 100 cycles.
